// File: rtl/conv_layer_controller.sv
// Frame sequencer for a convolutional_layer: gates its clk_en, tags completed filter windows,
// flushes the layer pipeline at end of frame and presents each tagged result exactly once.
module conv_layer_controller #(
  parameter int IMAGE_SIZE  = 64,
  parameter int FILTER_SIZE = 2,
  parameter int STRIDE      = 1,
  parameter int LATENCY     = 1,
  parameter int CW          = $clog2(IMAGE_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          conv_clk_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          busy,
  output logic          frame_done
);

  localparam int FW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(IMAGE_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      row_q, row_d, col_q, col_d;
  logic [LATENCY-1:0] tag_q, tag_d;
  logic               consumed_q, consumed_d;
  logic [FW-1:0]      flush_q, flush_d;
  logic               stall, adv, accept, tag_in, last_px;
  int                 r_off, c_off;

  // A pixel closes a window when it is the bottom-right corner of a stride-aligned filter footprint.
  always_comb begin
    r_off  = int'(row_q) - (FILTER_SIZE - 1);
    c_off  = int'(col_q) - (FILTER_SIZE - 1);
    tag_in = (r_off >= 0) && (c_off >= 0) &&
             ((r_off % STRIDE) == 0) && ((c_off % STRIDE) == 0);
  end

  assign out_valid   = tag_q[LATENCY-1] & ~consumed_q;
  assign stall       = out_valid & ~out_ready;
  assign adv         = ~stall & (((state_q == RUN) & in_valid) | (state_q == FLUSH));
  assign accept      = adv & (state_q == RUN);
  assign in_ready    = (state_q == RUN) & ~stall;
  assign conv_clk_en = adv;
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DRAIN) & ~out_valid;
  assign last_px     = (row_q == LAST) && (col_q == LAST);
  assign row         = row_q;
  assign col         = col_q;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    tag_d      = tag_q;
    consumed_d = consumed_q;
    flush_d    = flush_q;

    // Flush advances shift in zeros so only real windows ever reach the tail.
    if (adv) begin
      tag_d      = (tag_q << 1) | LATENCY'(accept & tag_in);
      consumed_d = 1'b0;
    end else if (out_valid && out_ready) begin
      consumed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          row_d      = '0;
          col_d      = '0;
          tag_d      = '0;
          consumed_d = 1'b0;
          flush_d    = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (col_q == LAST) begin
            col_d = '0;
            row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (last_px) begin
            state_d = FLUSH;
            flush_d = '0;
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          if (flush_q == FW'(LATENCY - 1)) state_d = DRAIN;
          else flush_d = flush_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!out_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      tag_q      <= '0;
      consumed_q <= 1'b0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      tag_q      <= tag_d;
      consumed_q <= consumed_d;
      flush_q    <= flush_d;
    end
  end

endmodule

// File: doc/conv_layer_controller.md
Name: conv_layer_controller

Overview:
- Sequences one frame through a convolutional_layer instance by driving its clk_en.
- Accepts an upstream pixel stream (valid/ready) and tracks row/column within the IMAGE_SIZE x IMAGE_SIZE frame.
- Tags which accepted pixels complete a valid filter window (respecting STRIDE) and presents the layer output to downstream with valid/ready backpressure.
- Flushes the layer pipeline at end of frame and pulses frame_done.

Parameters:
- IMAGE_SIZE, 64, frame width and height in pixels.
- FILTER_SIZE, 2, square filter edge length; must be >= 1 and <= IMAGE_SIZE.
- STRIDE, 1, window step in both dimensions; must be >= 1.
- LATENCY, 1, number of clk_en advances from a pixel entering the layer to the output that reflects it; must be >= 1.
- CW, $clog2(IMAGE_SIZE), row/column counter width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin frame; sampled only in IDLE.
- in_valid  in  1  upstream pixel present on layer input_data.
- in_ready  out  1  pixel accepted this cycle when in_valid & in_ready.
- conv_clk_en  out  1  drives convolutional_layer clk_en.
- out_valid  out  1  layer output_data is a valid window result.
- out_ready  in  1  downstream accepts output.
- row  out  CW  row index of the next pixel to be accepted.
- col  out  CW  column index of the next pixel to be accepted.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset values: state = IDLE; row = col = 0; tag pipe = 0; consumed = 0; all outputs 0.
- States:
  - IDLE: start -> RUN. Clears row, col, tag pipe and consumed on the transition.
  - RUN: accepts pixels. On acceptance of (IMAGE_SIZE-1, IMAGE_SIZE-1) -> FLUSH.
  - FLUSH: LATENCY advances with no input; a flush counter counts the advances. After the LATENCY-th advance -> DRAIN.
  - DRAIN: waits until out_valid == 0, then -> IDLE with frame_done = 1 for that one cycle.
- Stall condition: stall = out_valid & ~out_ready.
- Advance condition: adv = ~stall & ((RUN & in_valid) | FLUSH).
  - conv_clk_en = adv.
  - in_ready = RUN & ~stall. It is combinational and does not depend on in_valid.
- Tag computation for an accepted pixel (r, c):
  - tag = (r >= FILTER_SIZE-1) & (c >= FILTER_SIZE-1) & ((r-FILTER_SIZE+1) % STRIDE == 0) & ((c-FILTER_SIZE+1) % STRIDE == 0).
  - Flush advances inject tag = 0.
- Tag pipe: LATENCY-deep shift register that shifts only on adv. Its tail is the tag for the current output_data.
- Output valid and duplicate suppression:
  - out_valid = tail & ~consumed.
  - consumed is set on out_valid & out_ready when no adv occurs that cycle.
  - consumed is cleared on any adv.
  - Each tagged window is therefore presented exactly once.
- Simultaneous transfer and advance: out_valid & out_ready with adv in the same cycle is legal. The next tail appears the following cycle.
- Counters: advance only on pixel acceptance.
  - col wraps IMAGE_SIZE-1 -> 0 and increments row.
  - row wraps to 0 after the last pixel of the frame.
- start outside IDLE is ignored.
- rst mid-frame: immediate return to reset values; any partial frame is discarded and frame_done is not pulsed.
- Outputs per frame: ((IMAGE_SIZE-FILTER_SIZE)/STRIDE + 1)^2, integer division.

Test Plan:
- IMAGE_SIZE=4, FILTER_SIZE=2, STRIDE=1, LATENCY=1; start, then in_valid held high and out_ready held high -> 16 accepts on consecutive cycles; out_valid high for exactly 9 transfers; the first transfer occurs 1 cycle after pixel (1,1) is accepted; frame_done pulses once; busy low afterwards.
- Same configuration with STRIDE=2 -> 4 transfers, corresponding to windows ending at (1,1), (1,3), (3,1) and (3,3).
- out_ready held low for 5 cycles while out_valid=1 -> conv_clk_en=0 and in_ready=0 throughout; row and col frozen; a single transfer occurs on release.
- in_valid toggled 1/0 each cycle with out_ready=1 -> no duplicate out_valid during gap cycles; total transfers = 9; row/col advance only on accepts.
- LATENCY=3, final pixel accepted -> exactly 3 FLUSH cycles with conv_clk_en=1 and in_ready=0; the last window is transferred, then frame_done fires.
- rst asserted mid-frame at row=2 -> all outputs return to reset values immediately; the next start restarts at (0,0); frame_done does not pulse for the aborted frame.
